key_event_decoder: RTL and testbench

- Consumes the debounced key interface (KEY_EN level, KEY_UP press/repeat pulse) and classifies each gesture as short press, double press or long press.
- Emits one-cycle event pulses to the countdown-timer control FSM, plus a level that stays high while a long press is held.
- One instance sits per key, downstream of the switch debouncer, and shares its CE tick.

---
 rtl/key_event_decoder.sv | 135 +++++++++++++
 tb/tb_key_event_decoder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : key_event_decoder
// Purpose  : Classifies debounced key gestures into short / double / long
//            press pulses. Optional auto-repeat forwarding: KEY_EVT_REPEAT_FWD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module key_event_decoder #(
    parameter int CNT_BITS     = 8,
    parameter int LONG_TICKS   = 100,
    parameter int DOUBLE_TICKS = 30
) (
    input  logic CLK,
    input  logic CLR_N,
    input  logic CE,
    input  logic KEY_EN,
    input  logic KEY_UP,
    output logic SHORT_P,
    output logic DOUBLE_P,
    output logic LONG_P,
    output logic HELD,
    output logic REP_P,
    output logic BUSY
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRESSED  = 3'd1,
        S_WAIT2    = 3'd2,
        S_PRESSED2 = 3'd3,
        S_LONG     = 3'd4
    } state_t;

    localparam logic [CNT_BITS-1:0] LONG_LAST   = CNT_BITS'(LONG_TICKS - 1);
    localparam logic [CNT_BITS-1:0] DOUBLE_LAST = CNT_BITS'(DOUBLE_TICKS - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX     = '1;

    state_t              state;
    state_t              state_nx;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] cnt_nx;
    logic                cnt_run;
    logic                short_nx;
    logic                double_nx;
    logic                long_nx;

    // Release beats the long threshold; a second press beats the window timeout.
    always_comb begin
        state_nx  = state;
        cnt_run   = 1'b0;
        short_nx  = 1'b0;
        double_nx = 1'b0;
        long_nx   = 1'b0;
        case (state)
            S_IDLE: begin
                if (KEY_UP) state_nx = S_PRESSED;
            end
            S_PRESSED: begin
                if (!KEY_EN) begin
                    state_nx = S_WAIT2;
                end else if (CE && (cnt == LONG_LAST)) begin
                    state_nx = S_LONG;
                    long_nx  = 1'b1;
                end else begin
                    cnt_run = 1'b1;
                end
            end
            S_WAIT2: begin
                if (KEY_UP) begin
                    state_nx  = S_PRESSED2;
                    double_nx = 1'b1;
                end else if (CE && (cnt == DOUBLE_LAST)) begin
                    state_nx = S_IDLE;
                    short_nx = 1'b1;
                end else begin
                    cnt_run = 1'b1;
                end
            end
            S_PRESSED2: begin
                if (!KEY_EN) state_nx = S_IDLE;
            end
            S_LONG: begin
                if (!KEY_EN) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_nx = cnt;
        if (state_nx != state) begin
            cnt_nx = '0;
        end else if (cnt_run && CE && (cnt != CNT_MAX)) begin
            cnt_nx = cnt + CNT_BITS'(1);
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state    <= S_IDLE;
            cnt      <= '0;
            SHORT_P  <= 1'b0;
            DOUBLE_P <= 1'b0;
            LONG_P   <= 1'b0;
            HELD     <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            SHORT_P  <= short_nx;
            DOUBLE_P <= double_nx;
            LONG_P   <= long_nx;
            HELD     <= (state_nx == S_LONG);
            BUSY     <= (state_nx != S_IDLE);
        end
    end

`ifdef KEY_EVT_REPEAT_FWD_EN
    logic rep_q;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            rep_q <= 1'b0;
        end else begin
            rep_q <= (state == S_LONG) && KEY_UP;
        end
    end

    assign REP_P = rep_q;
`else
    assign REP_P = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_event_decoder
// Purpose  : Directed gesture scenarios plus randomized key traffic compared
//            against a tick-counting gesture model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_event_decoder;

    localparam int LT = 10;
    localparam int DT = 4;

    logic clk = 1'b0;
    logic clr_n;
    logic ce;
    logic key_en;
    logic key_up;
    logic short_p, double_p, long_p, held, rep_p, busy;

    int checks   = 0;
    int failures = 0;

    // Gesture model: phase 0 idle, 1 first hold, 2 gap, 3 second hold, 4 long hold
    int   m_phase = 0;
    int   m_ticks = 0;
    logic e_short, e_double, e_long, e_rep, e_held, e_busy;

    key_event_decoder #(
        .CNT_BITS    (8),
        .LONG_TICKS  (LT),
        .DOUBLE_TICKS(DT)
    ) dut (
        .CLK     (clk),
        .CLR_N   (clr_n),
        .CE      (ce),
        .KEY_EN  (key_en),
        .KEY_UP  (key_up),
        .SHORT_P (short_p),
        .DOUBLE_P(double_p),
        .LONG_P  (long_p),
        .HELD    (held),
        .REP_P   (rep_p),
        .BUSY    (busy)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_phase  = 0;
        m_ticks  = 0;
        e_short  = 1'b0;
        e_double = 1'b0;
        e_long   = 1'b0;
        e_rep    = 1'b0;
        e_held   = 1'b0;
        e_busy   = 1'b0;
    endtask

    task automatic model_edge(input logic c, input logic en, input logic up);
        e_short  = 1'b0;
        e_double = 1'b0;
        e_long   = 1'b0;
        e_rep    = 1'b0;
        if (m_phase == 0) begin
            if (up) begin m_phase = 1; m_ticks = 0; end
        end else if (m_phase == 1) begin
            if (!en) begin
                m_phase = 2; m_ticks = 0;
            end else if (c) begin
                m_ticks++;
                if (m_ticks == LT) begin m_phase = 4; e_long = 1'b1; end
            end
        end else if (m_phase == 2) begin
            if (up) begin
                m_phase = 3; e_double = 1'b1;
            end else if (c) begin
                m_ticks++;
                if (m_ticks == DT) begin m_phase = 0; e_short = 1'b1; end
            end
        end else if (m_phase == 3) begin
            if (!en) m_phase = 0;
        end else begin
`ifdef KEY_EVT_REPEAT_FWD_EN
            e_rep = up;
`endif
            if (!en) m_phase = 0;
        end
        e_held = (m_phase == 4);
        e_busy = (m_phase != 0);
    endtask

    // Drive one cycle of inputs, clock it in, advance the model, settle past the edge.
    task automatic step(input logic c, input logic en, input logic up);
        ce     = c;
        key_en = en;
        key_up = up;
        @(posedge clk);
        if (clr_n) model_edge(c, en, up);
        else       model_clear();
        #1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0; ce = 1'b0; key_en = 1'b0; key_up = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (short_p  !== 1'b0) begin failures++; $display("FAIL reset_short got=%b exp=0", short_p); end
        checks++; if (double_p !== 1'b0) begin failures++; $display("FAIL reset_double got=%b exp=0", double_p); end
        checks++; if (long_p   !== 1'b0) begin failures++; $display("FAIL reset_long got=%b exp=0", long_p); end
        checks++; if (held     !== 1'b0) begin failures++; $display("FAIL reset_held got=%b exp=0", held); end
        checks++; if (rep_p    !== 1'b0) begin failures++; $display("FAIL reset_rep got=%b exp=0", rep_p); end
        checks++; if (busy     !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        #3 clr_n = 1'b1;
        step(1, 0, 0);
    endtask

    task automatic test_short();
        int short_at = -1;
        int nshort   = 0;
        int others   = 0;
        step(1, 1, 1);
        step(1, 1, 0);
        step(1, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 0);
            if (short_p) begin nshort++; if (short_at < 0) short_at = i; end
            if (double_p || long_p || held) others++;
        end
        checks++; if (short_at !== 5) begin failures++; $display("FAIL short_timing got=%0d exp=5", short_at); end
        checks++; if (nshort !== 1) begin failures++; $display("FAIL short_count got=%0d exp=1", nshort); end
        checks++; if (others !== 0) begin failures++; $display("FAIL short_other_events got=%0d exp=0", others); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL short_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_double();
        int extra = 0;
        step(1, 1, 1);
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 1);
        checks++; if (double_p !== 1'b1) begin failures++; $display("FAIL double_pulse got=%b exp=1", double_p); end
        checks++; if (short_p !== 1'b0) begin failures++; $display("FAIL double_no_short got=%b exp=0", short_p); end
        step(1, 1, 0);
        checks++; if (double_p !== 1'b0) begin failures++; $display("FAIL double_one_cycle got=%b exp=0", double_p); end
        step(1, 0, 0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL double_busy_after got=%b exp=0", busy); end
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0);
            if (short_p || double_p || long_p || busy) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL double_quiet_after got=%0d exp=0", extra); end
    endtask

    task automatic test_long();
        int long_at  = -1;
        int nlong    = 0;
        int nheld    = 0;
        int nrep     = 0;
        int exp_rep;
`ifdef KEY_EVT_REPEAT_FWD_EN
        exp_rep = 3;
`else
        exp_rep = 0;
`endif
        step(1, 1, 1);
        for (int i = 1; i <= 20; i++) begin
            step(1, 1, (i % 3) == 0);
            if (long_p) begin nlong++; if (long_at < 0) long_at = i; end
            if (held) nheld++;
            if (rep_p) nrep++;
        end
        checks++; if (long_at !== 10) begin failures++; $display("FAIL long_timing got=%0d exp=10", long_at); end
        checks++; if (nlong !== 1) begin failures++; $display("FAIL long_count got=%0d exp=1", nlong); end
        checks++; if (nheld !== 11) begin failures++; $display("FAIL long_held_cycles got=%0d exp=11", nheld); end
        checks++; if (nrep !== exp_rep) begin failures++; $display("FAIL long_rep_count got=%0d exp=%0d", nrep, exp_rep); end
        step(1, 0, 0);
        checks++; if (held !== 1'b0) begin failures++; $display("FAIL long_held_drop got=%b exp=0", held); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL long_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_collision();
        int short_at = -1;
        int nlong    = 0;
        step(1, 1, 1);
        for (int i = 1; i <= 9; i++) step(1, 1, 0);
        step(1, 0, 0);
        if (long_p) nlong++;
        for (int j = 1; j <= 6; j++) begin
            step(1, 0, 0);
            if (long_p) nlong++;
            if (short_p && short_at < 0) short_at = j;
        end
        checks++; if (nlong !== 0) begin failures++; $display("FAIL coll_release_no_long got=%0d exp=0", nlong); end
        checks++; if (short_at !== 4) begin failures++; $display("FAIL coll_release_short got=%0d exp=4", short_at); end
        step(1, 1, 1);
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 1);
        checks++; if (double_p !== 1'b1) begin failures++; $display("FAIL coll_timeout_double got=%b exp=1", double_p); end
        checks++; if (short_p !== 1'b0) begin failures++; $display("FAIL coll_timeout_no_short got=%b exp=0", short_p); end
        step(1, 0, 0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL coll_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_async_reset();
        int events = 0;
        step(1, 1, 1);
        for (int i = 1; i <= 12; i++) step(1, 1, 0);
        checks++; if (held !== 1'b1) begin failures++; $display("FAIL arst_pre_held got=%b exp=1", held); end
        #2 clr_n = 1'b0;
        #1;
        checks++; if (held !== 1'b0) begin failures++; $display("FAIL arst_held_immediate got=%b exp=0", held); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy_immediate got=%b exp=0", busy); end
        @(posedge clk);
        model_clear();
        #3 clr_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0);
            if (short_p || double_p || long_p || held || busy || rep_p) events++;
        end
        checks++; if (events !== 0) begin failures++; $display("FAIL arst_stays_idle got=%0d exp=0", events); end
        step(1, 0, 0);
    endtask

    task automatic test_random();
        logic en = 1'b0;
        logic up;
        logic c;
        for (int n = 0; n < 3000; n++) begin
            c  = ($urandom_range(0, 9) < 8);
            up = 1'b0;
            if (!en) begin
                if ($urandom_range(0, 9) == 0) begin en = 1'b1; up = 1'b1; end
                else if ($urandom_range(0, 63) == 0) en = 1'b1;
            end else begin
                if ($urandom_range(0, 13) == 0) en = 1'b0;
                else if ($urandom_range(0, 4) == 0) up = 1'b1;
            end
            step(c, en, up);
            checks++; if (short_p  !== e_short)  begin failures++; $display("FAIL rand_short n=%0d got=%b exp=%b", n, short_p, e_short); end
            checks++; if (double_p !== e_double) begin failures++; $display("FAIL rand_double n=%0d got=%b exp=%b", n, double_p, e_double); end
            checks++; if (long_p   !== e_long)   begin failures++; $display("FAIL rand_long n=%0d got=%b exp=%b", n, long_p, e_long); end
            checks++; if (held     !== e_held)   begin failures++; $display("FAIL rand_held n=%0d got=%b exp=%b", n, held, e_held); end
            checks++; if (rep_p    !== e_rep)    begin failures++; $display("FAIL rand_rep n=%0d got=%b exp=%b", n, rep_p, e_rep); end
            checks++; if (busy     !== e_busy)   begin failures++; $display("FAIL rand_busy n=%0d got=%b exp=%b", n, busy, e_busy); end
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_double();
        test_long();
        test_collision();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
